// File: rtl/mm_bus_arbiter_pkg.sv
// Shared types and constants for the memory-mapped bus arbiter.
// Holds the FSM state encoding, bus widths and the default timeout read data.
package mm_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_e;

endpackage

// File: rtl/mm_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping at NUM_REQ. Returns a one-hot grant, its index and a valid flag.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    int k;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      k = int'(ptr) + off;
      if (k >= NUM_REQ) begin
        k = k - NUM_REQ;
      end
      if (!valid && req[k]) begin
        valid    = 1'b1;
        grant[k] = 1'b1;
        idx      = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/mm_bus_arbiter.sv
// Round-robin arbiter sharing one memory-mapped bus among NUM_REQ masters.
// Optional ack timeout enabled with `define MM_ARB_TIMEOUT_EN.
module mm_bus_arbiter
  import mm_bus_pkg::*;
#(
  parameter int                NUM_REQ        = 2,
  parameter int                TIMEOUT_CYCLES = 16,
  parameter logic [DATA_W-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ-1:0]          req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]          done_o,
  output logic [NUM_REQ-1:0]          err_o,
  output logic [NUM_REQ*DATA_W-1:0]   rdata_o,
  output logic                        write_o,
  output logic                        read_o,
  output logic [ADDR_W-1:0]           addr_o,
  output logic [DATA_W-1:0]           data_o,
  input  logic [DATA_W-1:0]           data_i,
  input  logic                        ack_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state_reg;
  logic [IDX_W-1:0]    ptr_reg;
  logic [IDX_W-1:0]    gnt_idx_reg;
  logic [NUM_REQ-1:0]  gnt_oh_reg;
  logic [NUM_REQ-1:0]  done_reg;
  logic [NUM_REQ-1:0]  err_reg;
  logic                write_reg;
  logic                read_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rdata_reg [NUM_REQ];

  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;
  logic [IDX_W-1:0]    ptr_next;
  logic                ack_ok;
  logic                timeout;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_master
      assign addr_arr[gi]                  = req_addr_i[ADDR_W*gi +: ADDR_W];
      assign wdata_arr[gi]                 = req_wdata_i[DATA_W*gi +: DATA_W];
      assign rdata_o[DATA_W*gi +: DATA_W]  = rdata_reg[gi];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req   (req_i),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Undriven (z) or unknown ack must never complete a transaction.
  assign ack_ok   = (ack_i === 1'b1);
  assign ptr_next = (gnt_idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_reg + 1'b1;

`ifdef MM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || state_reg != ACCESS) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign timeout = (state_reg == ACCESS) && !ack_ok &&
                   (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      gnt_idx_reg <= '0;
      gnt_oh_reg  <= '0;
      done_reg    <= '0;
      err_reg     <= '0;
      write_reg   <= 1'b0;
      read_reg    <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        rdata_reg[k] <= '0;
      end
    end else begin
      done_reg <= '0;
      err_reg  <= '0;
      case (state_reg)
        IDLE: begin
          if (arb_valid) begin
            gnt_idx_reg <= arb_idx;
            gnt_oh_reg  <= arb_grant;
            write_reg   <= req_write_i[arb_idx];
            read_reg    <= ~req_write_i[arb_idx];
            addr_reg    <= addr_arr[arb_idx];
            wdata_reg   <= wdata_arr[arb_idx];
            state_reg   <= ACCESS;
          end
        end
        ACCESS: begin
          if (ack_ok || timeout) begin
            if (!ack_ok) begin
              rdata_reg[gnt_idx_reg] <= ERR_DATA;
            end else if (!write_reg) begin
              rdata_reg[gnt_idx_reg] <= data_i;
            end
            done_reg  <= gnt_oh_reg;
            err_reg   <= ack_ok ? '0 : gnt_oh_reg;
            write_reg <= 1'b0;
            read_reg  <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            state_reg <= RESP;
          end
        end
        RESP: begin
          ptr_reg   <= ptr_next;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Without the timeout feature err_reg can only ever load zero.
  assign done_o  = done_reg;
  assign err_o   = err_reg;
  assign write_o = write_reg;
  assign read_o  = read_reg;
  assign addr_o  = addr_reg;
  assign data_o  = wdata_reg;

endmodule
